// File: rtl/rdy_vld_sink_fifo_pkg.sv
// Shared constants, types and elaboration helpers for rdy_vld_sink_fifo.
// RDY_VLD_SINK_FIFO_STALL_STATS_EN sizes its stall counter with STALL_CNT_W.
package rdy_vld_sink_fifo_pkg;

  localparam int unsigned STALL_CNT_W = 32;

  // Wide event counter type (stall statistics).
  typedef logic [STALL_CNT_W-1:0] count_t;

  // Occupancy counter width for a given depth: must hold 0..depth inclusive.
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Legal depth: a power of two, at least 2.
  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/rdy_vld_sink_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module rdy_vld_sink_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rdy_vld_sink_fifo.sv
// Ready/valid FIFO with a write-side data mask and occupancy output.
// Define RDY_VLD_SINK_FIFO_STALL_STATS_EN to add the saturating stall_cycles counter.
module rdy_vld_sink_fifo
  import rdy_vld_sink_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic [DATA_WIDTH-1:0]        data_mask,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef RDY_VLD_SINK_FIFO_STALL_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0]       stall_cycles
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = count_w(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("rdy_vld_sink_fifo: DEPTH must be a power of two and at least 2");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 1024) begin : g_bad_width
    $error("rdy_vld_sink_fifo: DATA_WIDTH must be in 1..1024");
  end

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full_q;
  logic             push_c;
  logic             pop_c;
  logic [CNT_W-1:0] count_nxt_c;

  // Handshakes depend only on registered flags; s_ready is held low during reset.
  assign s_ready = !full_q && !rst;
  assign push_c  = s_valid && s_ready;
  assign pop_c   = m_valid && m_ready;

  always_comb begin
    count_nxt_c = count;
    count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Occupancy, pointers and the full/valid flags all advance together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      m_valid <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      count   <= count_nxt_c;
      m_valid <= (count_nxt_c != '0);
      full_q  <= (count_nxt_c == CNT_W'(DEPTH));
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  rdy_vld_sink_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_c),
    .waddr (wr_ptr),
    .wdata (s_data & data_mask),
    .raddr (rd_ptr),
    .rdata (m_data)
  );

`ifdef RDY_VLD_SINK_FIFO_STALL_STATS_EN
  count_t stall_cnt;

  // Cycles where the source is held off; saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (s_valid && !s_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + count_t'(1);
    end
  end

  assign stall_cycles = stall_cnt;
`endif

endmodule
